// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: deserialises device-to-host frames and assembles 3-byte movement packets.
// Pins are synchronised, the clock is glitch-filtered, and stalled frames/packets time out.
module ps2_mouse_packet_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_mouse_dx,
    output logic [7:0] o_mouse_dy,
    output logic       o_is_mouse_dx_neg,
    output logic       o_is_mouse_dy_neg,
    output logic [2:0] o_btn,
    output logic [1:0] o_overflow,
    output logic       o_valid,
    output logic       o_err
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]     clk_sync_q, data_sync_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic           filt_clk_q, filt_dly_q, edge_q;
    logic           data_s;

    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [1:0]     idx_q, idx_d;
    logic [6:0]     byte0_q, byte0_d;   // byte0 without bit3, which is always 1
    logic [7:0]     dx_q, dx_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]     out_dx_q, out_dx_d, out_dy_q, out_dy_d;
    logic [6:0]     out_st_q, out_st_d;
    logic           valid_q, valid_d, err_q, err_d;
    logic           frame_done, frame_ok, active;

    assign data_s = data_sync_q[1];

    // Synchronisers and clock filter; idle bus level is high.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_dly_q  <= 1'b1;
            edge_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], i_ps2_clk};
            data_sync_q <= {data_sync_q[0], i_ps2_data};
            if (clk_sync_q[1] == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_clk_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
            filt_dly_q <= filt_clk_q;
            edge_q     <= filt_dly_q & ~filt_clk_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            idx_q     <= '0;
            byte0_q   <= '0;
            dx_q      <= '0;
            to_cnt_q  <= '0;
            out_dx_q  <= '0;
            out_dy_q  <= '0;
            out_st_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            idx_q     <= idx_d;
            byte0_q   <= byte0_d;
            dx_q      <= dx_d;
            to_cnt_q  <= to_cnt_d;
            out_dx_q  <= out_dx_d;
            out_dy_q  <= out_dy_d;
            out_st_q  <= out_st_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        idx_d      = idx_q;
        byte0_d    = byte0_q;
        dx_d       = dx_q;
        to_cnt_d   = to_cnt_q;
        out_dx_d   = out_dx_q;
        out_dy_d   = out_dy_q;
        out_st_d   = out_st_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        frame_done = 1'b0;
        frame_ok   = 1'b0;
        active     = (state_q != StIdle) || (idx_q != 2'd0);

        if (edge_q) begin
            to_cnt_d = '0;
            case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    frame_done = 1'b1;
                    frame_ok   = (^{shift_q, parity_q}) & data_s;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (active) begin
            if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = StIdle;
                idx_d    = '0;
                err_d    = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        if (frame_done) begin
            if (!frame_ok) begin
                err_d = 1'b1;
                idx_d = '0;
            end else begin
                case (idx_q)
                    2'd0: begin
                        // bit3 marks a packet header; anything else is a resync drop
                        if (shift_q[3]) begin
                            byte0_d = {shift_q[7:4], shift_q[2:0]};
                            idx_d   = 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_d  = shift_q;
                        idx_d = 2'd2;
                    end
                    2'd2: begin
                        out_st_d = byte0_q;
                        out_dx_d = dx_q;
                        out_dy_d = shift_q;
                        valid_d  = 1'b1;
                        idx_d    = '0;
                    end
                    default: idx_d = '0;
                endcase
            end
        end
    end

    assign o_mouse_dx        = out_dx_q;
    assign o_mouse_dy        = out_dy_q;
    assign o_overflow        = out_st_q[6:5];
    assign o_is_mouse_dy_neg = out_st_q[4];
    assign o_is_mouse_dx_neg = out_st_q[3];
    assign o_btn             = out_st_q[2:0];
    assign o_valid           = valid_q;
    assign o_err             = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Self-checking bench for ps2_mouse_packet_rx: drives PS/2 frames and compares against
// a packet-level model (byte index, header bit, parity/timeout drops).
module tb_ps2_mouse_packet_rx;

    localparam int unsigned FILT = 8;
    localparam int unsigned TO   = 1500;
    localparam int unsigned HALF = 30;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] o_mouse_dx, o_mouse_dy;
    logic       o_is_mouse_dx_neg, o_is_mouse_dy_neg;
    logic [2:0] o_btn;
    logic [1:0] o_overflow;
    logic       o_valid, o_err;

    ps2_mouse_packet_rx #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_ps2_clk        (ps2_clk),
        .i_ps2_data       (ps2_data),
        .o_mouse_dx       (o_mouse_dx),
        .o_mouse_dy       (o_mouse_dy),
        .o_is_mouse_dx_neg(o_is_mouse_dx_neg),
        .o_is_mouse_dy_neg(o_is_mouse_dy_neg),
        .o_btn            (o_btn),
        .o_overflow       (o_overflow),
        .o_valid          (o_valid),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, valid_cnt = 0, err_cnt = 0, last_valid_cyc = 0, last_fall_cyc = 0;
    logic prev_valid = 1'b0;

    // Packet-level model state
    int         m_idx = 0, exp_valid = 0, exp_err = 0;
    logic [7:0] m_b0 = '0, m_dx = '0, exp_b0 = '0, exp_dx = '0, exp_dy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid || o_err) begin
            vectors++;
            if ((o_valid && o_err) || (o_valid && prev_valid)) begin
                miscompares++;
                $display("FAIL pulse_shape: valid=%b err=%b prev_valid=%b required single valid, never with err",
                         o_valid, o_err, prev_valid);
            end
        end
        if (o_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (o_err) err_cnt++;
        prev_valid = o_valid;
    end

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_idx = 0;
        end else begin
            case (m_idx)
                0: if (b[3]) begin m_b0 = b; m_idx = 1; end
                1: begin m_dx = b; m_idx = 2; end
                default: begin
                    exp_b0 = m_b0; exp_dx = m_dx; exp_dy = b;
                    exp_valid++;
                    m_idx = 0;
                end
            endcase
        end
    endtask

    task automatic model_timeout();
        if (m_idx != 0) begin
            exp_err++;
            m_idx = 0;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_parity);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(HALF + $urandom_range(0, 20));
        model_frame(b, !bad_parity);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0);
        send_frame(b1, 1'b0);
        send_frame(b2, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({o_mouse_dx, o_mouse_dy, o_is_mouse_dx_neg, o_is_mouse_dy_neg, o_btn, o_overflow,
             o_valid, o_err} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got dx=%h dy=%h btn=%b ovf=%b v=%b e=%b required all 0",
                     o_mouse_dx, o_mouse_dy, o_btn, o_overflow, o_valid, o_err);
        end
        wait_clks(5);
        arst_n = 1'b1;
        wait_clks(20);
    endtask

    task automatic test_basic();
        send_packet(8'h18, 8'hF6, 8'h05);
        wait_clks(20);
        vectors++;
        if ({o_mouse_dx, o_is_mouse_dx_neg, o_mouse_dy, o_is_mouse_dy_neg, o_btn, o_overflow}
                !== {8'hF6, 1'b1, 8'h05, 1'b0, 3'b000, 2'b00}) begin
            miscompares++;
            $display("FAIL basic_packet: got dx=%h xn=%b dy=%h yn=%b btn=%b ovf=%b required F6 1 05 0 000 00",
                     o_mouse_dx, o_is_mouse_dx_neg, o_mouse_dy, o_is_mouse_dy_neg, o_btn, o_overflow);
        end
        vectors++;
        if (valid_cnt !== 1 || err_cnt !== 0) begin
            miscompares++;
            $display("FAIL basic_counts: got valid=%0d err=%0d required 1 0", valid_cnt, err_cnt);
        end
    endtask

    task automatic test_btn_latency();
        send_packet(8'h09, 8'h01, 8'h02);
        wait_clks(20);
        vectors++;
        if ({o_btn, o_mouse_dx, o_mouse_dy} !== {3'b001, 8'h01, 8'h02}) begin
            miscompares++;
            $display("FAIL btn_packet: got btn=%b dx=%h dy=%h required 001 01 02", o_btn, o_mouse_dx, o_mouse_dy);
        end
        vectors++;
        // raw fall -> 2 sync + FILT filter samples -> edge event -> registered valid
        if ((last_valid_cyc - last_fall_cyc) < int'(FILT + 3) ||
            (last_valid_cyc - last_fall_cyc) > int'(FILT + 5) || valid_cnt !== exp_valid) begin
            miscompares++;
            $display("FAIL valid_latency: got %0d cycles (valids %0d) required %0d..%0d (valids %0d)",
                     last_valid_cyc - last_fall_cyc, valid_cnt, FILT + 3, FILT + 5, exp_valid);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h18, 1'b0);
        send_frame(8'h33, 1'b1);
        wait_clks(20);
        vectors++;
        if (err_cnt !== exp_err || valid_cnt !== exp_valid || exp_err !== 1) begin
            miscompares++;
            $display("FAIL parity_drop: got err=%0d valid=%0d required err=%0d valid=%0d",
                     err_cnt, valid_cnt, exp_err, exp_valid);
        end
        send_packet(8'h08, 8'h10, 8'h20);
        wait_clks(20);
        vectors++;
        if ({o_mouse_dx, o_mouse_dy, valid_cnt} !== {8'h10, 8'h20, exp_valid}) begin
            miscompares++;
            $display("FAIL parity_recover: got dx=%h dy=%h valid=%0d required 10 20 %0d",
                     o_mouse_dx, o_mouse_dy, valid_cnt, exp_valid);
        end
    endtask

    task automatic test_misaligned();
        send_frame(8'h00, 1'b0);
        send_packet(8'h08, 8'h03, 8'h04);
        wait_clks(20);
        vectors++;
        if ({o_mouse_dx, o_mouse_dy, valid_cnt, err_cnt} !== {8'h03, 8'h04, exp_valid, exp_err}) begin
            miscompares++;
            $display("FAIL misaligned: got dx=%h dy=%h valid=%0d err=%0d required 03 04 %0d %0d",
                     o_mouse_dx, o_mouse_dy, valid_cnt, err_cnt, exp_valid, exp_err);
        end
    endtask

    task automatic test_timeout();
        send_frame(8'h28, 1'b0);
        send_frame(8'h55, 1'b0);
        wait_clks(TO + 100);
        model_timeout();
        vectors++;
        if (err_cnt !== exp_err || valid_cnt !== exp_valid || o_mouse_dx !== 8'h03) begin
            miscompares++;
            $display("FAIL timeout_abort: got err=%0d valid=%0d dx=%h required %0d %0d 03",
                     err_cnt, valid_cnt, o_mouse_dx, exp_err, exp_valid);
        end
        send_packet(8'h08, 8'h07, 8'h09);
        wait_clks(20);
        vectors++;
        if ({o_mouse_dx, o_mouse_dy, o_btn} !== {8'h07, 8'h09, 3'b000} || valid_cnt !== exp_valid) begin
            miscompares++;
            $display("FAIL timeout_recover: got dx=%h dy=%h btn=%b valid=%0d required 07 09 000 %0d",
                     o_mouse_dx, o_mouse_dy, o_btn, valid_cnt, exp_valid);
        end
    endtask

    task automatic test_glitch();
        ps2_clk = 1'b0;
        wait_clks(3);
        ps2_clk = 1'b1;
        wait_clks(40);
        vectors++;
        if (err_cnt !== exp_err || valid_cnt !== exp_valid) begin
            miscompares++;
            $display("FAIL glitch_filter: got err=%0d valid=%0d required %0d %0d",
                     err_cnt, valid_cnt, exp_err, exp_valid);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b;
        b = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        arst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        m_idx = 0; exp_b0 = '0; exp_dx = '0; exp_dy = '0;
        #1;
        vectors++;
        if ({o_mouse_dx, o_mouse_dy, o_btn, o_overflow, o_is_mouse_dx_neg, o_is_mouse_dy_neg} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_mid_byte: got dx=%h dy=%h btn=%b required all 0",
                     o_mouse_dx, o_mouse_dy, o_btn);
        end
        wait_clks(5);
        arst_n = 1'b1;
        wait_clks(20);
        send_packet(8'hE8, 8'h81, 8'h7F);
        wait_clks(20);
        vectors++;
        if ({o_overflow, o_is_mouse_dy_neg, o_is_mouse_dx_neg, o_btn, o_mouse_dx, o_mouse_dy}
                !== {exp_b0[7:4], exp_b0[2:0], exp_dx, exp_dy} || valid_cnt !== exp_valid) begin
            miscompares++;
            $display("FAIL reset_recover: got dx=%h dy=%h valid=%0d required %h %h %0d",
                     o_mouse_dx, o_mouse_dy, valid_cnt, exp_dx, exp_dy, exp_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 3; k++) begin
                b = 8'($urandom);
                if (k == 0) b[3] = 1'b1;
                send_frame(b, $urandom_range(0, 7) == 0);
            end
            wait_clks(20);
            vectors++;
            if ({o_overflow, o_is_mouse_dy_neg, o_is_mouse_dx_neg, o_btn, o_mouse_dx, o_mouse_dy}
                    !== {exp_b0[7:4], exp_b0[2:0], exp_dx, exp_dy} ||
                valid_cnt !== exp_valid || err_cnt !== exp_err) begin
                miscompares++;
                $display("FAIL random_pkt%0d: got b0bits=%b dx=%h dy=%h v=%0d e=%0d required %b %h %h %0d %0d",
                         p, {o_overflow, o_is_mouse_dy_neg, o_is_mouse_dx_neg, o_btn}, o_mouse_dx,
                         o_mouse_dy, valid_cnt, err_cnt, {exp_b0[7:4], exp_b0[2:0]}, exp_dx, exp_dy,
                         exp_valid, exp_err);
            end
        end
        wait_clks(TO + 100);
        model_timeout();
        vectors++;
        if (err_cnt !== exp_err || valid_cnt !== exp_valid) begin
            miscompares++;
            $display("FAIL random_flush: got err=%0d valid=%0d required %0d %0d",
                     err_cnt, valid_cnt, exp_err, exp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_btn_latency();
        test_parity();
        test_misaligned();
        test_timeout();
        test_glitch();
        test_reset_mid_byte();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
